// File: rtl/rose_not_checker.sv
// rtl/rose_not_checker.sv - runtime checker for "trig |=> not rose(sig)" with counters and halt.
// Optional first-failure timestamp capture enabled by ROSE_CHK_TIMESTAMP_EN.
module rose_not_checker #(
  parameter int          CNT_W        = 16,
  parameter int          CYC_W        = 32,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             trig,
  input  logic             sig,
  output logic             fail_pulse,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] eval_cnt,
  output logic             halted,
  output logic [CYC_W-1:0] cyc_cnt,
  output logic [CYC_W-1:0] first_fail_cyc
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MONITOR = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  state_t           r_state;
  logic             r_sig_q;
  logic             r_pending;
  logic             r_fail_pulse;
  logic             r_fail_sticky;
  logic             r_halted;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_eval_cnt;
  logic [CYC_W-1:0] r_cyc_cnt;

  logic w_rose;
  logic w_fail;

  assign w_rose = sig & ~r_sig_q;
  // A failing evaluation only counts when it is not overridden by clr or a dropped enable.
  assign w_fail = (r_state == S_MONITOR) && en && !clr && r_pending && w_rose;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_q   <= 1'b0;
      r_cyc_cnt <= '0;
    end else begin
      r_sig_q   <= sig;
      r_cyc_cnt <= r_cyc_cnt + CYC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pending     <= 1'b0;
      r_fail_pulse  <= 1'b0;
      r_fail_sticky <= 1'b0;
      r_halted      <= 1'b0;
      r_fail_cnt    <= '0;
      r_eval_cnt    <= '0;
    end else begin
      r_fail_pulse <= 1'b0;
      if (clr) begin
        r_pending     <= 1'b0;
        r_fail_sticky <= 1'b0;
        r_halted      <= 1'b0;
        r_fail_cnt    <= '0;
        r_eval_cnt    <= '0;
        r_state       <= en ? S_MONITOR : S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_pending <= 1'b0;
            if (en) r_state <= S_MONITOR;
          end
          S_MONITOR: begin
            if (!en) begin
              r_pending <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              if (r_pending) begin
                if (r_eval_cnt != CNT_MAX) r_eval_cnt <= r_eval_cnt + CNT_ONE;
                if (w_rose) begin
                  r_fail_pulse  <= 1'b1;
                  r_fail_sticky <= 1'b1;
                  if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
                end
              end
              if (w_fail && (STOP_ON_FAIL != 0)) begin
                r_pending <= 1'b0;
                r_halted  <= 1'b1;
                r_state   <= S_HALTED;
              end else begin
                r_pending <= trig;
              end
            end
          end
          S_HALTED: begin
            r_pending <= 1'b0;
          end
          default: begin
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef ROSE_CHK_TIMESTAMP_EN
  logic [CYC_W-1:0] r_first_fail_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_fail_cyc <= '0;
    end else if (clr) begin
      r_first_fail_cyc <= '0;
    end else if (w_fail && !r_fail_sticky) begin
      r_first_fail_cyc <= r_cyc_cnt;
    end
  end

  assign first_fail_cyc = r_first_fail_cyc;
`else
  assign first_fail_cyc = '0;
`endif

  assign fail_pulse  = r_fail_pulse;
  assign fail_sticky = r_fail_sticky;
  assign fail_cnt    = r_fail_cnt;
  assign eval_cnt    = r_eval_cnt;
  assign halted      = r_halted;
  assign cyc_cnt     = r_cyc_cnt;

endmodule

// File: tb/tb_rose_not_checker.sv
// tb/tb_rose_not_checker.sv - scoreboard bench for rose_not_checker, three parameter sets in parallel.
module tb_rose_not_checker;

  typedef struct {
    logic        pulse;
    logic        sticky;
    logic        halted;
    int unsigned fcnt;
    int unsigned ecnt;
    logic [31:0] cyc;
    logic [31:0] ffc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, en, clr, trig, sig;

  logic        o_pulse[3];
  logic        o_sticky[3];
  logic        o_halt[3];
  logic [31:0] o_cyc[3];
  logic [31:0] o_ffc[3];
  logic [15:0] fc0, ec0, fc1, ec1;
  logic [1:0]  fc2, ec2;
  logic [31:0] act_fc[3];
  logic [31:0] act_ec[3];

  assign act_fc[0] = {16'd0, fc0};
  assign act_fc[1] = {16'd0, fc1};
  assign act_fc[2] = {30'd0, fc2};
  assign act_ec[0] = {16'd0, ec0};
  assign act_ec[1] = {16'd0, ec1};
  assign act_ec[2] = {30'd0, ec2};

  rose_not_checker #(.CNT_W(16), .CYC_W(32), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .sig(sig),
    .fail_pulse(o_pulse[0]), .fail_sticky(o_sticky[0]), .fail_cnt(fc0), .eval_cnt(ec0),
    .halted(o_halt[0]), .cyc_cnt(o_cyc[0]), .first_fail_cyc(o_ffc[0]));

  rose_not_checker #(.CNT_W(16), .CYC_W(32), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .sig(sig),
    .fail_pulse(o_pulse[1]), .fail_sticky(o_sticky[1]), .fail_cnt(fc1), .eval_cnt(ec1),
    .halted(o_halt[1]), .cyc_cnt(o_cyc[1]), .first_fail_cyc(o_ffc[1]));

  rose_not_checker #(.CNT_W(2), .CYC_W(32), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .sig(sig),
    .fail_pulse(o_pulse[2]), .fail_sticky(o_sticky[2]), .fail_cnt(fc2), .eval_cnt(ec2),
    .halted(o_halt[2]), .cyc_cnt(o_cyc[2]), .first_fail_cyc(o_ffc[2]));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-instance configuration: stop-on-fail flag and counter ceiling.
  bit          cfg_stop[3] = '{1'b0, 1'b1, 1'b0};
  int unsigned cfg_max[3]  = '{32'd65535, 32'd65535, 32'd3};

  // Reference model: which triggers are awaiting judgement and what has been tallied.
  bit          m_prev;
  logic [31:0] m_cyc;
  bit          m_active[3];
  bit          m_halt[3];
  bit          m_pend[3];
  bit          m_sticky[3];
  bit          m_pulse[3];
  int unsigned m_fcnt[3];
  int unsigned m_ecnt[3];
  logic [31:0] m_ffc[3];

  exp_t sbq[3][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0;
    m_cyc  = 32'd0;
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 1'b0; m_halt[i] = 1'b0; m_pend[i] = 1'b0;
      m_sticky[i] = 1'b0; m_pulse[i] = 1'b0;
      m_fcnt[i] = 0; m_ecnt[i] = 0; m_ffc[i] = 32'd0;
    end
  endtask

  task automatic model_step(input bit e, input bit c, input bit t, input bit s);
    bit rose;
    rose = s && !m_prev;
    for (int i = 0; i < 3; i++) begin
      m_pulse[i] = 1'b0;
      if (c) begin
        m_fcnt[i] = 0; m_ecnt[i] = 0; m_sticky[i] = 1'b0; m_ffc[i] = 32'd0;
        m_pend[i] = 1'b0; m_halt[i] = 1'b0; m_active[i] = e;
      end else if (m_halt[i]) begin
        m_pend[i] = 1'b0;
      end else if (!m_active[i]) begin
        m_pend[i] = 1'b0;
        m_active[i] = e;
      end else if (!e) begin
        m_active[i] = 1'b0;
        m_pend[i] = 1'b0;
      end else begin
        if (m_pend[i]) begin
          if (m_ecnt[i] < cfg_max[i]) m_ecnt[i]++;
          if (rose) begin
            m_pulse[i] = 1'b1;
            if (m_fcnt[i] < cfg_max[i]) m_fcnt[i]++;
            if (!m_sticky[i]) m_ffc[i] = m_cyc;
            m_sticky[i] = 1'b1;
            if (cfg_stop[i]) m_halt[i] = 1'b1;
          end
        end
        m_pend[i] = t && !m_halt[i];
      end
    end
    m_prev = s;
    m_cyc  = m_cyc + 32'd1;
  endtask

  task automatic push_exp();
    for (int i = 0; i < 3; i++) begin
      exp_t x;
      x.pulse  = m_pulse[i];
      x.sticky = m_sticky[i];
      x.halted = m_halt[i];
      x.fcnt   = m_fcnt[i];
      x.ecnt   = m_ecnt[i];
      x.cyc    = m_cyc;
`ifdef ROSE_CHK_TIMESTAMP_EN
      x.ffc    = m_ffc[i];
`else
      x.ffc    = 32'd0;
`endif
      sbq[i].push_back(x);
    end
  endtask

  task automatic cycle(input bit e, input bit c, input bit t, input bit s);
    en = e; clr = c; trig = t; sig = s;
    if (rst_n) model_step(e, c, t, s);
    else model_reset();
    push_exp();
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sbq[i].size() != 0) begin
          exp_t x;
          x = sbq[i].pop_front();
          chk($sformatf("d%0d.fail_pulse", i), 32'(o_pulse[i]), 32'(x.pulse));
          chk($sformatf("d%0d.fail_sticky", i), 32'(o_sticky[i]), 32'(x.sticky));
          chk($sformatf("d%0d.halted", i), 32'(o_halt[i]), 32'(x.halted));
          chk($sformatf("d%0d.fail_cnt", i), act_fc[i], x.fcnt);
          chk($sformatf("d%0d.eval_cnt", i), act_ec[i], x.ecnt);
          chk($sformatf("d%0d.cyc_cnt", i), o_cyc[i], x.cyc);
          chk($sformatf("d%0d.first_fail_cyc", i), o_ffc[i], x.ffc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; trig = 1'b0; sig = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Toggling sig, triggers on the low phase: every evaluation sees a rise.
    for (int k = 0; k < 14; k++) cycle(1'b1, 1'b0, (k % 2) == 0, (k % 2) == 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    // Triggers on the high phase: evaluations all pass.
    for (int k = 0; k < 14; k++) cycle(1'b1, 1'b0, (k % 2) == 1, (k % 2) == 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    // clr landing on a failing evaluation.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // en dropped on the evaluating edge.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Same-edge clr and trig: trigger is dropped.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 300; k++)
      cycle(($urandom % 16) != 0, ($urandom % 40) == 0, 1'($urandom % 2), 1'($urandom % 2));

    // Reset asserted while an evaluation is pending.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d.async_rst_pulse", i), 32'(o_pulse[i]), 32'd0);
      chk($sformatf("d%0d.async_rst_cyc", i), o_cyc[i], 32'd0);
      chk($sformatf("d%0d.async_rst_sticky", i), 32'(o_sticky[i]), 32'd0);
    end
    chk("d2.async_rst_fail_cnt", act_fc[2], 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Rise-heavy random traffic to exercise saturation and halting.
    for (int k = 0; k < 300; k++)
      cycle(($urandom % 32) != 0, ($urandom % 60) == 0, 1'($urandom % 4 != 0), (k % 2) == 1);

    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("d%0d.scoreboard_drained", i), sbq[i].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
